// File: rtl/alu_ctrl_defs.sv
// Shared definitions for the ALU operand-path controller: state encodings and default widths.
package alu_ctrl_defs;

    localparam int DEF_SIZE_SW        = 16;
    localparam int DEF_SIZE_OPERANDOS = 9;
    localparam int DEF_SIZE_OPERACION = 6;

    typedef enum logic [1:0] {
        S_WAIT_A  = 2'b00,
        S_WAIT_B  = 2'b01,
        S_WAIT_OP = 2'b10,
        S_SHOW    = 2'b11
    } state_t;

endpackage

// File: rtl/btn_debouncer.sv
// Button conditioner: 2-FF synchronizer, stability counter and a one-cycle rising-edge event.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // debounced level; the final disagreeing cycle flips the level instead.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// ALU operand front end: debounces three buttons and loads A, B, then opcode from the switches.
module alu_input_sequencer
    import alu_ctrl_defs::*;
#(
    parameter int SIZE_SW         = DEF_SIZE_SW,
    parameter int SIZE_OPERANDOS  = DEF_SIZE_OPERANDOS,
    parameter int SIZE_OPERACION  = DEF_SIZE_OPERACION,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [SIZE_SW-1:0]        i_sw,
    input  logic                      i_btn_a,
    input  logic                      i_btn_b,
    input  logic                      i_btn_op,
    output logic [SIZE_OPERANDOS-1:0] o_a,
    output logic [SIZE_OPERANDOS-1:0] o_b,
    output logic [SIZE_OPERACION-1:0] o_opcode,
    output logic                      o_load_a,
    output logic                      o_load_b,
    output logic                      o_load_op,
    output logic                      o_exec,
    output logic                      o_seq_err,
    output logic [1:0]                o_state
);

    logic                      ev_a, ev_b, ev_op;
    logic [2:0]                btn_lvl_unused;
    logic                      sw_hi_unused;
    state_t                    state_q, state_d;
    logic [SIZE_OPERANDOS-1:0] a_q, a_d, b_q, b_d;
    logic [SIZE_OPERACION-1:0] op_q, op_d;
    logic                      ld_a_q, ld_a_d, ld_b_q, ld_b_d, ld_op_q, ld_op_d, err_q, err_d;

    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_a),
        .o_level(btn_lvl_unused[0]), .o_rise(ev_a));
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_b),
        .o_level(btn_lvl_unused[1]), .o_rise(ev_b));
    btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
        .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_op),
        .o_level(btn_lvl_unused[2]), .o_rise(ev_op));

    // Upper switch bits are deliberately ignored; operands are plain truncations.
    assign sw_hi_unused = ^i_sw[SIZE_SW-1:SIZE_OPERANDOS];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        ld_a_d  = 1'b0;
        ld_b_d  = 1'b0;
        ld_op_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_WAIT_A, S_SHOW: begin
                if (ev_a) begin
                    a_d     = i_sw[SIZE_OPERANDOS-1:0];
                    ld_a_d  = 1'b1;
                    state_d = S_WAIT_B;
                end else if (ev_b || ev_op) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT_B: begin
                if (ev_b) begin
                    b_d     = i_sw[SIZE_OPERANDOS-1:0];
                    ld_b_d  = 1'b1;
                    state_d = S_WAIT_OP;
                end else if (ev_a || ev_op) begin
                    err_d = 1'b1;
                end
            end
            S_WAIT_OP: begin
                if (ev_op) begin
                    op_d    = i_sw[SIZE_OPERACION-1:0];
                    ld_op_d = 1'b1;
                    state_d = S_SHOW;
                end else if (ev_a || ev_b) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = S_WAIT_A;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= S_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            ld_a_q  <= 1'b0;
            ld_b_q  <= 1'b0;
            ld_op_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            ld_a_q  <= ld_a_d;
            ld_b_q  <= ld_b_d;
            ld_op_q <= ld_op_d;
            err_q   <= err_d;
        end
    end

    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_opcode  = op_q;
    assign o_load_a  = ld_a_q;
    assign o_load_b  = ld_b_q;
    assign o_load_op = ld_op_q;
    assign o_exec    = ld_op_q;
    assign o_seq_err = err_q;
    assign o_state   = state_q;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Scoreboard bench for alu_input_sequencer with a 4-cycle debounce window.
module tb_alu_input_sequencer;

    localparam int D   = 4;
    localparam int LAT = D + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw = '0;
    logic        btn_a = 1'b0, btn_b = 1'b0, btn_op = 1'b0;
    logic [8:0]  o_a, o_b;
    logic [5:0]  o_opcode;
    logic        o_load_a, o_load_b, o_load_op, o_exec, o_seq_err;
    logic [1:0]  o_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    // flags = {load_a, load_b, load_op, exec, seq_err}
    typedef struct {
        int         cyc;
        logic [4:0] flags;
        logic [8:0] a;
        logic [8:0] b;
        logic [5:0] op;
        logic [1:0] st;
    } exp_t;

    exp_t sbq[$];

    alu_input_sequencer #(.DEBOUNCE_CYCLES(D)) dut (
        .i_clock(clk), .i_reset(rst), .i_sw(sw),
        .i_btn_a(btn_a), .i_btn_b(btn_b), .i_btn_op(btn_op),
        .o_a(o_a), .o_b(o_b), .o_opcode(o_opcode),
        .o_load_a(o_load_a), .o_load_b(o_load_b), .o_load_op(o_load_op),
        .o_exec(o_exec), .o_seq_err(o_seq_err), .o_state(o_state));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [4:0] f, input logic [8:0] a,
                        input logic [8:0] b, input logic [5:0] op, input logic [1:0] st);
        exp_t e;
        e.cyc = c; e.flags = f; e.a = a; e.b = b; e.op = op; e.st = st;
        sbq.push_back(e);
    endtask

    // Monitor: pops one expectation per strobe cycle; flags expectations that went stale.
    always @(negedge clk) begin
        if (!done) begin
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                chk("missing_event_cycle", 32'(cyc), 32'(sbq[0].cyc));
                void'(sbq.pop_front());
            end
            if (o_load_a || o_load_b || o_load_op || o_exec || o_seq_err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_strobe", {27'd0, o_load_a, o_load_b, o_load_op, o_exec, o_seq_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("event_cycle", 32'(cyc), 32'(e.cyc));
                    chk("strobes", {27'd0, o_load_a, o_load_b, o_load_op, o_exec, o_seq_err}, {27'd0, e.flags});
                    chk("o_a", {23'd0, o_a}, {23'd0, e.a});
                    chk("o_b", {23'd0, o_b}, {23'd0, e.b});
                    chk("o_opcode", {26'd0, o_opcode}, {26'd0, e.op});
                    chk("o_state", {30'd0, o_state}, {30'd0, e.st});
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // btns = {a, b, op}; the expectation is queued before the event can occur.
    task automatic press(input logic [2:0] btns, input logic [15:0] s, input bit has_exp,
                         input logic [4:0] f, input logic [8:0] a, input logic [8:0] b,
                         input logic [5:0] op, input logic [1:0] st);
        @(negedge clk);
        if (has_exp) push(cyc + LAT, f, a, b, op, st);
        sw = s;
        {btn_a, btn_b, btn_op} = btns;
        idle(10);
        {btn_a, btn_b, btn_op} = 3'b000;
        idle(15);
    endtask

    task automatic check_idle_state(input string tag, input logic [8:0] a, input logic [8:0] b,
                                    input logic [5:0] op, input logic [1:0] st);
        chk({tag, "_a"}, {23'd0, o_a}, {23'd0, a});
        chk({tag, "_b"}, {23'd0, o_b}, {23'd0, b});
        chk({tag, "_op"}, {26'd0, o_opcode}, {26'd0, op});
        chk({tag, "_state"}, {30'd0, o_state}, {30'd0, st});
        chk({tag, "_strobes"}, {27'd0, o_load_a, o_load_b, o_load_op, o_exec, o_seq_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        check_idle_state("reset", 9'd0, 9'd0, 6'd0, 2'b00);

        // Clean A press, then full sequence
        press(3'b100, 16'h0005, 1'b1, 5'b10000, 9'd5, 9'd0, 6'h00, 2'b01);
        press(3'b010, 16'h0003, 1'b1, 5'b01000, 9'd5, 9'd3, 6'h00, 2'b10);
        press(3'b001, 16'h0020, 1'b1, 5'b00110, 9'd5, 9'd3, 6'h20, 2'b11);
        check_idle_state("after_seq", 9'd5, 9'd3, 6'h20, 2'b11);

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_state("reset2", 9'd0, 9'd0, 6'd0, 2'b00);

        // Bouncing A: two-cycle pulses never survive the stability window
        sw = 16'h0011;
        for (int i = 0; i < 3; i++) begin
            btn_a = 1'b1; idle(2);
            btn_a = 1'b0; idle(2);
        end
        idle(20);
        check_idle_state("bounce", 9'd0, 9'd0, 6'd0, 2'b00);

        // Out-of-order B in S_WAIT_A, then A accepted
        press(3'b010, 16'h0007, 1'b1, 5'b00001, 9'd0, 9'd0, 6'h00, 2'b00);
        press(3'b100, 16'h0009, 1'b1, 5'b10000, 9'd9, 9'd0, 6'h00, 2'b01);
        press(3'b010, 16'h0002, 1'b1, 5'b01000, 9'd9, 9'd2, 6'h00, 2'b10);

        // Reset in S_WAIT_OP while OP is held: stale press becomes a sequence error
        @(negedge clk);
        t0 = cyc;
        sw = 16'h0011;
        btn_op = 1'b1;
        idle(3);
        rst = 1'b1;
        push(t0 + 4 + LAT, 5'b00001, 9'd0, 9'd0, 6'h00, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        check_idle_state("reset_mid", 9'd0, 9'd0, 6'd0, 2'b00);
        idle(16);
        btn_op = 1'b0;
        idle(15);
        check_idle_state("after_stale_op", 9'd0, 9'd0, 6'd0, 2'b00);

        // Simultaneous A and B in S_WAIT_B: B wins silently; truncation of wide switches
        press(3'b100, 16'h0001, 1'b1, 5'b10000, 9'd1, 9'd0, 6'h00, 2'b01);
        press(3'b110, 16'h0004, 1'b1, 5'b01000, 9'd1, 9'd4, 6'h00, 2'b10);
        press(3'b001, 16'hFFEA, 1'b1, 5'b00110, 9'd1, 9'd4, 6'h2A, 2'b11);
        press(3'b100, 16'hFFFF, 1'b1, 5'b10000, 9'h1FF, 9'd4, 6'h2A, 2'b01);
        check_idle_state("final", 9'h1FF, 9'd4, 6'h2A, 2'b01);

        idle(5);
        done = 1'b1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
